// File: rtl/mult_pkg.sv
// Shared definitions for the iterative multiplier: FSM encodings, default width
// and the iteration-counter sizing helper.
package mult_pkg;

  localparam int MULT_WIDTH = 32;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_FIN  = 2'd2;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_width(MULT_WIDTH);

endpackage

// File: rtl/mult_sign_fix.sv
// Combinational conditional negate: res = neg ? -val : val (two's complement).
// Used both for operand magnitudes and for restoring the product sign.
module mult_sign_fix #(
  parameter int N = 32
) (
  input  logic [N-1:0] val,
  input  logic         neg,
  output logic [N-1:0] res
);

  assign res = neg ? (~val + {{(N-1){1'b0}}, 1'b1}) : val;

endmodule

// File: rtl/mult_iter.sv
// Radix-2 shift-add multiplier: WIDTH+1 cycles from start edge to ready_o pulse.
// No input backpressure: start_i is only honoured in IDLE; annul_i aborts without a result.
module mult_iter
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_mult_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam int CW = cnt_width(WIDTH);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic               neg;

  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;
  logic [2*WIDTH-1:0] prod;

  // |-2^(WIDTH-1)| wraps to the same bit pattern, which is correct read as unsigned.
  mult_sign_fix #(.N(WIDTH)) u_abs1 (
    .val (opdata1_i),
    .neg (signed_mult_i & opdata1_i[WIDTH-1]),
    .res (mag1)
  );

  mult_sign_fix #(.N(WIDTH)) u_abs2 (
    .val (opdata2_i),
    .neg (signed_mult_i & opdata2_i[WIDTH-1]),
    .res (mag2)
  );

  mult_sign_fix #(.N(2*WIDTH)) u_fix (
    .val (acc),
    .neg (neg),
    .res (prod)
  );

  assign busy_o = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      mcand    <= '0;
      acc      <= '0;
      mplier   <= '0;
      neg      <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i && !annul_i) begin
            mcand  <= {{WIDTH{1'b0}}, mag1};
            mplier <= mag2;
            acc    <= '0;
            cnt    <= '0;
            neg    <= signed_mult_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            state  <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (annul_i) begin
            state <= ST_IDLE;
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) state <= ST_FIN;
          end
        end
        ST_FIN: begin
          // A flush on the completion edge wins: no pulse, old result kept.
          if (!annul_i) begin
            result_o <= prod;
            ready_o  <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_iter.sv
// Scoreboard bench for mult_iter: directed vectors at WIDTH=32 and WIDTH=8,
// expected products and completion edges queued at issue, checked on ready_o.
module tb_mult_iter;

  typedef struct {
    logic [63:0] r;
    int          e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        sgn = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        start = 1'b0;
  logic        annul = 1'b0;
  logic [63:0] result;
  logic        ready;
  logic        busy;

  logic        sgn8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        start8 = 1'b0;
  logic        annul8 = 1'b0;
  logic [15:0] result8;
  logic        ready8;
  logic        busy8;

  int   edges = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t q32[$];
  exp_t q8[$];

  mult_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .signed_mult_i(sgn), .opdata1_i(a), .opdata2_i(b),
    .start_i(start), .annul_i(annul), .result_o(result), .ready_o(ready), .busy_o(busy)
  );

  mult_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .signed_mult_i(sgn8), .opdata1_i(a8), .opdata2_i(b8),
    .start_i(start8), .annul_i(annul8), .result_o(result8), .ready_o(ready8), .busy_o(busy8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: every ready pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && ready) begin
      if (q32.size() == 0) begin
        chk("unexpected_ready32", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q32.pop_front();
        chk("result32", result, e.r);
        chk("latency32_edge", 64'(edges), 64'(e.e));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ready8) begin
      if (q8.size() == 0) begin
        chk("unexpected_ready8", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("result8", 64'(result8), e.r);
        chk("latency8_edge", 64'(edges), 64'(e.e));
      end
    end
  end

  // Called #1 after an edge; returns #1 after the start edge with operands scrambled.
  task automatic issue(input logic s, input logic [31:0] x, input logic [31:0] y,
                       input logic push, input logic [63:0] exp);
    exp_t e;
    sgn = s; a = x; b = y; start = 1'b1;
    e.r = exp;
    e.e = edges + 1 + 33;
    if (push) q32.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; sgn = $urandom_range(0, 1);
  endtask

  task automatic issue8(input logic s, input logic [7:0] x, input logic [7:0] y,
                        input logic [15:0] exp);
    exp_t e;
    sgn8 = s; a8 = x; b8 = y; start8 = 1'b1;
    e.r = 64'(exp);
    e.e = edges + 1 + 9;
    q8.push_back(e);
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && (q32.size() != 0 || q8.size() != 0 || busy || busy8); i++) begin
      @(posedge clk); #1;
    end
    if (q32.size() != 0 || q8.size() != 0 || busy || busy8)
      chk("timeout_wait_done", 64'd1, 64'd0);
  endtask

  initial begin
    int busy_cnt;
    #1;
    chk("reset_result", result, 64'd0);
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Unsigned max x max, with busy counted until the ready pulse.
    issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFE00000001);
    busy_cnt = 0;
    for (int i = 0; i < 100 && !ready; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    chk("busy_cycles", 64'(busy_cnt), 64'd33);
    wait_done();

    issue(1'b1, 32'hFFFFFFFD, 32'h00000007, 1'b1, 64'hFFFFFFFFFFFFFFEB);
    wait_done();
    issue(1'b1, 32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000);
    wait_done();
    issue(1'b0, 32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000);
    wait_done();
    issue(1'b1, 32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF80000000);
    wait_done();
    issue(1'b1, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFF80000001);
    wait_done();

    // start with annul in IDLE is ignored
    sgn = 1'b0; a = 32'd5; b = 32'd6; start = 1'b1; annul = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    chk("start_with_annul_busy", 64'(busy), 64'd0);

    // Annul during CALC
    issue(1'b0, 32'd5, 32'd6, 1'b0, 64'd0);
    repeat (9) @(posedge clk);
    #1 annul = 1'b1;
    @(posedge clk); #1 annul = 1'b0;
    chk("annul_calc_busy", 64'(busy), 64'd0);
    chk("annul_calc_result_kept", result, 64'hFFFFFFFF80000001);
    issue(1'b0, 32'd5, 32'd6, 1'b1, 64'h1E);
    wait_done();

    // Annul on the FIN edge beats completion
    issue(1'b0, 32'd7, 32'd7, 1'b0, 64'd0);
    repeat (32) @(posedge clk);
    #1 chk("fin_busy", 64'(busy), 64'd1);
    annul = 1'b1;
    @(posedge clk); #1 annul = 1'b0;
    chk("annul_fin_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #1 chk("annul_fin_result_kept", result, 64'h1E);

    // Start while busy is ignored; start on the ready cycle is accepted
    issue(1'b0, 32'd2, 32'd3, 1'b1, 64'd6);
    repeat (4) @(posedge clk);
    #1 sgn = 1'b0; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 100 && !ready; i++) begin
      @(posedge clk); #1;
    end
    if (ready) issue(1'b0, 32'd4, 32'd4, 1'b1, 64'h10);
    else chk("timeout_ready_b2b", 64'd1, 64'd0);
    wait_done();

    // Asynchronous reset mid-CALC
    issue(1'b0, 32'h1234, 32'h5678, 1'b0, 64'd0);
    repeat (14) @(posedge clk);
    chk("pre_reset_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_reset_result", result, 64'd0);
    chk("async_reset_busy", 64'(busy), 64'd0);
    chk("async_reset_ready", 64'(ready), 64'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    issue(1'b0, 32'h0, 32'h12345678, 1'b1, 64'd0);
    wait_done();

    // Parametric WIDTH=8
    issue8(1'b1, 8'h80, 8'h7F, 16'hC080);
    wait_done();
    issue8(1'b0, 8'hFF, 8'hFF, 16'hFE01);
    wait_done();
    issue8(1'b1, 8'hFF, 8'hFF, 16'h0001);
    wait_done();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
